// File: rtl/div_ctrl.sv
// div_ctrl: sequencing stage around a combinational restoring divider.
//
// Operand pairs arrive on a valid/ready input and are buffered in a
// 2-entry FIFO. For each pair the block drives the divider operand bus,
// holds it for SETTLE cycles, samples the quotient, derives the remainder
// and presents the result on a valid/ready output with full backpressure.
// A zero denominator bypasses the divider and reports divide-by-zero
// (quotient all ones, remainder = numerator) on the next edge.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operand pair offered
//   in_ready   FIFO can accept (from registered occupancy only)
//   in_a       numerator
//   in_b       denominator
//   div_a      registered numerator to the divider
//   div_b      registered denominator to the divider
//   div_q      quotient returned by the divider
//   out_valid  result available
//   out_ready  downstream accepts the result
//   out_q      quotient
//   out_r      remainder
//   out_dbz    divide-by-zero flag
module div_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2   // legal range 1..15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dbz
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;

  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] fifo_a_q [2];
  logic [WIDTH-1:0] fifo_a_d [2];
  logic [WIDTH-1:0] fifo_b_q [2];
  logic [WIDTH-1:0] fifo_b_d [2];

  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             valid_q, valid_d;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [WIDTH-1:0] rem_calc;

  // in_ready looks only at the registered count, so a full FIFO refuses a
  // push even when the same edge would pop an entry.
  assign in_ready = (count_q != 2'd2);
  assign push     = in_valid && in_ready;
  assign head_a   = fifo_a_q[rd_ptr_q];
  assign head_b   = fifo_b_q[rd_ptr_q];

  // Remainder a - q*b, product formed at double width, unsigned; only the
  // low WIDTH bits are kept.
  assign rem_calc = WIDTH'(W2'(opa_q) - (W2'(div_q) * W2'(opb_q)));

  // A new entry is taken when idle, or in DONE on the output handshake so
  // consecutive operations run back-to-back without an IDLE bubble.
  assign pop = (count_q != 2'd0) &&
               ((state_q == IDLE) || ((state_q == DONE) && out_ready));

  // Next-state logic for the FIFO, the sequencer and the result registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fifo_a_d = fifo_a_q;
    fifo_b_d = fifo_b_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    valid_d  = valid_q;

    if (push) begin
      fifo_a_d[wr_ptr_q] = in_a;
      fifo_b_d[wr_ptr_q] = in_b;
      wr_ptr_d           = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          quo_d   = div_q;
          rem_d   = rem_calc;
          dbz_d   = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready && !pop) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Loading a popped entry; a zero denominator never touches the divider
    // bus and produces its result on this same edge.
    if (pop) begin
      if (head_b != '0) begin
        opa_d   = head_a;
        opb_d   = head_b;
        cnt_d   = 4'(SETTLE);
        valid_d = 1'b0;
        state_d = WAIT;
      end else begin
        quo_d   = '1;
        rem_d   = head_a;
        dbz_d   = 1'b1;
        valid_d = 1'b1;
        state_d = DONE;
      end
    end
  end

  // All state registers; reset discards any queued or in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fifo_a_q <= '{default: '0};
      fifo_b_q <= '{default: '0};
      opa_q    <= '0;
      opb_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fifo_a_q <= fifo_a_d;
      fifo_b_q <= fifo_b_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
      valid_q  <= valid_d;
    end
  end

  assign div_a     = opa_q;
  assign div_b     = opb_q;
  assign out_q     = quo_q;
  assign out_r     = rem_q;
  assign out_dbz   = dbz_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl. A behavioural divider
// closes the loop on div_a/div_b -> div_q, and expected results are queued
// when operands are accepted and compared when the block presents them.
module tb_div_ctrl;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic [WIDTH-1:0] div_q;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic             out_dbz;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  // Behavioural model of the combinational divider array.
  assign div_q = (div_b == '0) ? '1 : WIDTH'(div_a / div_b);

  div_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .div_a(div_a),
    .div_b(div_b),
    .div_q(div_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q(out_q),
    .out_r(out_r),
    .out_dbz(out_dbz)
  );

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    res_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair and return just after the edge that accepts it.
  task automatic offer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!in_ready && guard < 40) begin
      tick();
      guard++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid rises; 99 signals an expired budget.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
    if (!out_valid) edges = 99;
  endtask

  task automatic test_reset();
    int e;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    offer(4'd11, 4'd2);
    wait_valid(e);
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, out_dbz, out_q, out_r, div_a, div_b} !== '0)
      $display("[TB] FAIL reset_async_outputs: got v=%0b dbz=%0b q=%0d r=%0d da=%0d db=%0d expected all 0",
               out_valid, out_dbz, out_q, out_r, div_a, div_b);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready);
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_nominal();
    int   e;
    res_t x;
    out_ready = 1'b0;
    offer(4'd13, 4'd3);
    sb.push_back(model(4'd13, 4'd3));
    tick();
    n_checks++;
    if (div_a !== 4'd13 || div_b !== 4'd3)
      $display("[TB] FAIL nominal_div_bus: got %0d/%0d expected 13/3", div_a, div_b);
    else n_pass++;
    wait_valid(e);
    e = e + 1;
    n_checks++;
    if (e !== SETTLE + 1) $display("[TB] FAIL nominal_latency: got %0d expected %0d", e, SETTLE + 1);
    else n_pass++;
    x = sb.pop_front();
    n_checks++;
    if ({out_q, out_r, out_dbz} !== {x.q, x.r, x.dbz})
      $display("[TB] FAIL nominal_result: got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
               out_q, out_r, out_dbz, x.q, x.r, x.dbz);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b1) $display("[TB] FAIL nominal_hold: got %0b expected 1", out_valid);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL nominal_drop: got %0b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_dbz();
    int   e;
    res_t x;
    offer(4'd9, 4'd0);
    sb.push_back(model(4'd9, 4'd0));
    wait_valid(e);
    n_checks++;
    if (e !== 1) $display("[TB] FAIL dbz_latency: got %0d expected 1", e);
    else n_pass++;
    x = sb.pop_front();
    n_checks++;
    if ({out_q, out_r, out_dbz} !== {x.q, x.r, x.dbz})
      $display("[TB] FAIL dbz_result: got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
               out_q, out_r, out_dbz, x.q, x.r, x.dbz);
    else n_pass++;
    n_checks++;
    if (div_a !== 4'd13 || div_b !== 4'd3)
      $display("[TB] FAIL dbz_div_bus_kept: got %0d/%0d expected 13/3", div_a, div_b);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_boundary();
    logic [WIDTH-1:0] ta [4];
    logic [WIDTH-1:0] tb [4];
    int   e;
    res_t x;
    ta = '{4'd15, 4'd3, 4'd15, 4'd0};
    tb = '{4'd1, 4'd7, 4'd15, 4'd5};
    for (int i = 0; i < 4; i++) begin
      offer(ta[i], tb[i]);
      sb.push_back(model(ta[i], tb[i]));
      wait_valid(e);
      n_checks++;
      if (e !== SETTLE + 1) $display("[TB] FAIL boundary_latency_%0d: got %0d expected %0d", i, e, SETTLE + 1);
      else n_pass++;
      x = sb.pop_front();
      n_checks++;
      if ({out_q, out_r, out_dbz} !== {x.q, x.r, x.dbz})
        $display("[TB] FAIL boundary_result_%0d: got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
                 i, out_q, out_r, out_dbz, x.q, x.r, x.dbz);
      else n_pass++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] ba [4];
    logic [WIDTH-1:0] bb [4];
    int   nxt, guard, got, e;
    logic acc, stable, extra;
    logic [2*WIDTH:0] held;
    res_t x;
    ba = '{4'd8, 4'd9, 4'd7, 4'd5};
    bb = '{4'd2, 4'd4, 4'd7, 4'd0};
    out_ready = 1'b0;
    nxt = 0; guard = 0;
    in_valid = 1'b1; in_a = ba[0]; in_b = bb[0];
    while (nxt < 3 && guard < 20) begin
      acc = in_valid && in_ready;
      tick();
      guard++;
      if (acc) begin
        sb.push_back(model(ba[nxt], bb[nxt]));
        nxt++;
        in_a = ba[nxt]; in_b = bb[nxt];
      end
    end
    n_checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL bp_full_in_ready: got %0b expected 0", in_ready);
    else n_pass++;
    wait_valid(e);
    held = {out_q, out_r, out_dbz};
    x = sb[0];
    n_checks++;
    if (held !== {x.q, x.r, x.dbz})
      $display("[TB] FAIL bp_first_result: got q=%0d r=%0d expected q=%0d r=%0d", out_q, out_r, x.q, x.r);
    else n_pass++;
    stable = 1'b1;
    repeat (4) begin
      tick();
      if (!out_valid || {out_q, out_r, out_dbz} !== held || in_ready) stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1) $display("[TB] FAIL bp_hold_stable: got %0b expected 1", stable);
    else n_pass++;
    out_ready = 1'b1;
    got = 0; guard = 0; extra = 1'b0;
    while (got < 4 && guard < 60) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        if (sb.size() == 0) extra = 1'b1;
        else begin
          x = sb.pop_front();
          n_checks++;
          if ({out_q, out_r, out_dbz} !== {x.q, x.r, x.dbz})
            $display("[TB] FAIL bp_result_%0d: got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
                     got, out_q, out_r, out_dbz, x.q, x.r, x.dbz);
          else n_pass++;
        end
        got++;
      end
      tick();
      guard++;
      if (acc) begin
        in_valid = 1'b0;
        sb.push_back(model(ba[3], bb[3]));
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (got !== 4 || extra) $display("[TB] FAIL bp_count: got %0d results expected 4", got);
    else n_pass++;
    repeat (5) begin
      tick();
      if (out_valid) extra = 1'b1;
    end
    out_ready = 1'b0;
    n_checks++;
    if (extra !== 1'b0) $display("[TB] FAIL bp_no_duplicate: got extra=%0b expected 0", extra);
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_reset_mid_wait();
    int   e;
    logic rose;
    res_t x;
    out_ready = 1'b0;
    offer(4'd14, 4'd3);
    tick();
    tick();
    reset = 1'b1;
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rose = 1'b0;
    repeat (10) begin
      tick();
      if (out_valid) rose = 1'b1;
    end
    n_checks++;
    if (rose !== 1'b0) $display("[TB] FAIL rst_wait_discard: got out_valid rise=%0b expected 0", rose);
    else n_pass++;
    offer(4'd6, 4'd2);
    sb.push_back(model(4'd6, 4'd2));
    wait_valid(e);
    n_checks++;
    if (e !== SETTLE + 1) $display("[TB] FAIL rst_wait_latency: got %0d expected %0d", e, SETTLE + 1);
    else n_pass++;
    x = sb.pop_front();
    n_checks++;
    if ({out_q, out_r, out_dbz} !== {x.q, x.r, x.dbz})
      $display("[TB] FAIL rst_wait_result: got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
               out_q, out_r, out_dbz, x.q, x.r, x.dbz);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_dbz();
    test_boundary();
    test_backpressure();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing stage wrapped around the combinational `divide` array (4-bit restoring divider).
- Accepts operand pairs on a valid/ready input and buffers them in a 2-entry queue.
- Drives the divider operand bus, waits a programmable settle time, then samples the quotient.
- Derives the remainder, flags divide-by-zero, and presents results on a valid/ready output with full backpressure.

Parameters:
- WIDTH, 4: operand/quotient/remainder width; must match the divider instance.
- SETTLE, 2: cycles operands are held before div_q is sampled; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  queue can accept (count < 2)
- in_a  input  WIDTH  numerator
- in_b  input  WIDTH  denominator
- div_a  output  WIDTH  numerator to divider, registered
- div_b  output  WIDTH  denominator to divider, registered
- div_q  input  WIDTH  quotient from divider
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts
- out_q  output  WIDTH  quotient
- out_r  output  WIDTH  remainder
- out_dbz  output  1  divide-by-zero flag

Behaviour:
- Reset (async, any state):
  - out_valid, out_q, out_r, out_dbz, div_a, div_b = 0.
  - Queue emptied; state IDLE; settle counter = 0.
  - Any in-flight operation is discarded with no output.
- Input queue:
  - 2-entry FIFO; push on in_valid && in_ready.
  - in_ready = (count < 2), computed from registered count only. A push into a full queue is refused even if a pop happens the same cycle.
  - Simultaneous push and pop with count = 1 leaves count = 1.
- FSM states: IDLE, WAIT, DONE.
- IDLE, queue non-empty:
  - Pop the head.
  - If b != 0: load div_a = a, div_b = b, settle counter = SETTLE, go to WAIT.
  - If b == 0: leave div_a/div_b unchanged; set out_q = all ones, out_r = a, out_dbz = 1, out_valid = 1; go to DONE.
- WAIT:
  - Decrement the counter each edge.
  - On the edge where the counter equals 1:
    - out_q = div_q.
    - out_r = low WIDTH bits of (a − div_q × b); the product is formed at 2×WIDTH.
    - out_dbz = 0, out_valid = 1; go to DONE.
- DONE:
  - out_valid held; out_q, out_r, out_dbz stable until out_valid && out_ready.
  - On handshake with queue non-empty: pop the next entry and apply the IDLE load rules in the same edge (back-to-back, no IDLE bubble). out_valid drops unless the popped entry has b == 0, in which case the new result appears immediately.
  - On handshake with queue empty: out_valid = 0, go to IDLE.
- Latency, measured from the accepting edge into an empty, idle block:
  - b != 0: out_valid at acceptance + SETTLE + 1 edges.
  - b == 0: out_valid at acceptance + 1 edge.
- div_a and div_b never change during WAIT or DONE.
- Remainder arithmetic is unsigned throughout; no sign extension.
- While out_valid is high, in_valid with queue not full is still accepted (buffering continues under backpressure).

Test Plan:
- Reset values: assert reset mid-cycle with no clock edge -> all outputs 0 immediately; in_ready = 1 after release.
- Nominal case, SETTLE = 2: push a = 13, b = 3 at edge E0 -> div_a = 13, div_b = 3 at E1; out_valid at E3; out_q = 4, out_r = 1, out_dbz = 0; out_valid falls after out_ready handshake.
- Divide by zero: push a = 9, b = 0 -> out_valid at E1; out_q = 15, out_r = 9, out_dbz = 1; div_a/div_b keep their previous values.
- Boundary operands, checked in order:
  - 15/1 -> q = 15, r = 0
  - 3/7 -> q = 0, r = 3
  - 15/15 -> q = 1, r = 0
  - 0/5 -> q = 0, r = 0
- Backpressure: hold out_ready = 0 and push 4 ops (8/2, 9/4, 7/7, 5/0) ->
  - First result (q = 4, r = 0) is held stable.
  - in_ready = 0 once 2 entries are queued; the 4th op stalls.
  - Release out_ready -> results 4/0, 2/1, 1/0, then 15/5 dbz, in order, with no loss or duplication.
- Reset mid-WAIT: push 14/3, assert reset 1 cycle after load -> out_valid never rises for that op; the next op after reset (6/2) returns q = 3, r = 0 with nominal latency.
